// File: rtl/chan_scan_mux_pkg.sv
// Shared types for chan_scan_mux: FSM state encodings and the dwell-counter width helper.
package chan_scan_mux_pkg;

    typedef enum logic [1:0] {
        S_MAN  = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // Counter width for a dwell of N cycles (counts 0..N-1); never narrower than one bit.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/chan_scan_mux_dwell_counter.sv
// Dwell counter for the auto-scan: counts 0..DWELL-1 while enabled, flags the last count.
module chan_scan_mux_dwell_counter #(
    parameter int DWELL = 4,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel registered mux with manual select, auto-scan with programmable dwell, and hold.
// Optional registered parity output data_par when CHAN_SCAN_PARITY_EN is defined.
module chan_scan_mux
    import chan_scan_mux_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data,
    output logic [SEL_W-1:0]          chan,
    output logic                      valid,
    output logic                      wrap
`ifdef CHAN_SCAN_PARITY_EN
    ,
    output logic                      data_par
`endif
);

    localparam int                 NSLOT   = 2 ** SEL_W;
    localparam int                 CNT_W   = dwell_cnt_w(DWELL);
    localparam logic [SEL_W-1:0]   LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]     NCH     = (SEL_W + 1)'(CHANNELS);

    // Select space is padded to 2**SEL_W slots so any index is legal; unused slots read zero.
    logic [WIDTH-1:0] slot [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_live
                assign slot[gi] = din[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign slot[gi] = '0;
            end
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SEL_W-1:0] chan_q,  chan_d;
    logic             valid_q, valid_d;
    logic             wrap_q,  wrap_d;
    logic             sel_ok;
    logic             chan_ok;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;

    assign sel_ok  = ({1'b0, sel}    < NCH);
    assign chan_ok = ({1'b0, chan_q} < NCH);

    chan_scan_mux_dwell_counter #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // The state chosen by this cycle's hold/mode also decides what is registered at this edge,
    // so every input reaches the outputs with the same one-cycle latency.
    always_comb begin
        state_d = hold ? S_HOLD : (mode ? S_SCAN : S_MAN);
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_d)
            S_MAN: begin
                chan_d  = sel;
                valid_d = sel_ok;
                data_d  = sel_ok ? slot[sel] : '0;
                cnt_clr = 1'b1;
            end
            S_SCAN: begin
                if (state_q == S_MAN || !chan_ok) begin
                    // Fresh scan: start on the current channel (or 0 if it is out of range).
                    chan_d  = chan_ok ? chan_q : '0;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        if (chan_q == LAST_CH) begin
                            chan_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            chan_d = chan_q + 1'b1;
                        end
                    end
                end
                data_d  = slot[chan_d];
                valid_d = 1'b1;
            end
            default: begin
                // S_HOLD: data, chan and dwell count stay put.
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_MAN;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data  = data_q;
    assign chan  = chan_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

`ifdef CHAN_SCAN_PARITY_EN
    // Parity of the value being registered; frozen along with data during hold.
    logic data_par_q;
    logic data_par_d;

    assign data_par_d = ^data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_par_q <= 1'b0;
        end else begin
            data_par_q <= data_par_d;
        end
    end

    assign data_par = data_par_q;
`endif

endmodule

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: default instance, a 3-channel instance, and
// (with CHAN_SCAN_PARITY_EN) a 4-bit instance exercising data_par.
module tb_chan_scan_mux;

    typedef struct packed {
        logic [1:0] data;
        logic [1:0] chan;
        logic       valid;
        logic       wrap;
    } exp_t;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] chan;
        logic       valid;
        logic       wrap;
        logic       par;
    } expp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance: WIDTH=2, CHANNELS=4, SEL_W=2, DWELL=4
    logic [7:0] din_a;
    logic       mode_a, hold_a;
    logic [1:0] sel_a;
    logic [1:0] data_a, chan_a;
    logic       valid_a, wrap_a;

    // Three-channel instance
    logic [5:0] din_b;
    logic       mode_b, hold_b;
    logic [1:0] sel_b;
    logic [1:0] data_b, chan_b;
    logic       valid_b, wrap_b;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t e;
    exp_t obs;

    logic [1:0] tbl_b [3] = '{2'b11, 2'b01, 2'b10};

`ifdef CHAN_SCAN_PARITY_EN
    chan_scan_mux u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .mode(mode_a), .sel(sel_a), .hold(hold_a),
        .data(data_a), .chan(chan_a), .valid(valid_a), .wrap(wrap_a), .data_par()
    );
    chan_scan_mux #(.CHANNELS(3)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .sel(sel_b), .hold(hold_b),
        .data(data_b), .chan(chan_b), .valid(valid_b), .wrap(wrap_b), .data_par()
    );

    logic [15:0] din_p;
    logic        mode_p, hold_p;
    logic [1:0]  sel_p;
    logic [3:0]  data_p;
    logic [1:0]  chan_p;
    logic        valid_p, wrap_p, par_p;
    expp_t       sb_p[$];
    expp_t       ep;
    expp_t       obsp;

    chan_scan_mux #(.WIDTH(4)) u_dut_p (
        .clk(clk), .rst(rst), .din(din_p), .mode(mode_p), .sel(sel_p), .hold(hold_p),
        .data(data_p), .chan(chan_p), .valid(valid_p), .wrap(wrap_p), .data_par(par_p)
    );
`else
    chan_scan_mux u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .mode(mode_a), .sel(sel_a), .hold(hold_a),
        .data(data_a), .chan(chan_a), .valid(valid_a), .wrap(wrap_a)
    );
    chan_scan_mux #(.CHANNELS(3)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .sel(sel_b), .hold(hold_b),
        .data(data_b), .chan(chan_b), .valid(valid_b), .wrap(wrap_b)
    );
`endif

    task automatic test_reset();
        rst    = 1'b1;
        mode_a = 1'b1; hold_a = 1'b0; sel_a = 2'd3;
        mode_b = 1'b1; hold_b = 1'b0; sel_b = 2'd2;
`ifdef CHAN_SCAN_PARITY_EN
        mode_p = 1'b1; hold_p = 1'b0; sel_p = 2'd1;
`endif
        for (int i = 0; i < 2; i++) begin
            din_a = 8'($urandom);
            din_b = 6'($urandom);
            sb_a.push_back('0);
            sb_b.push_back('0);
`ifdef CHAN_SCAN_PARITY_EN
            din_p = 16'($urandom);
            sb_p.push_back('0);
`endif
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_a cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            e = sb_b.pop_front(); obs = {data_b, chan_b, valid_b, wrap_b};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_b cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
`ifdef CHAN_SCAN_PARITY_EN
            ep = sb_p.pop_front(); obsp = {data_p, chan_p, valid_p, wrap_p, par_p};
            checks++;
            if (obsp !== ep) begin
                failures++;
                $display("FAIL reset_p cyc%0d: got %b expected %b (data,chan,valid,wrap,par)", i, obsp, ep);
            end
`endif
            $display("reset cyc%0d: a=%b b=%b", i, {data_a, chan_a, valid_a, wrap_a},
                     {data_b, chan_b, valid_b, wrap_b});
        end
        rst    = 1'b0;
        mode_a = 1'b0; sel_a = 2'd0; din_a = 8'h00;
        mode_b = 1'b0; sel_b = 2'd0; din_b = 6'h00;
`ifdef CHAN_SCAN_PARITY_EN
        mode_p = 1'b0; sel_p = 2'd0; din_p = 16'h0000;
`endif
    endtask

    task automatic test_manual();
        logic [7:0] dins [4] = '{8'b11_10_01_00, 8'b11_10_01_00, 8'b00_00_10_00, 8'b11_10_01_00};
        logic [1:0] sels [4] = '{2'd2, 2'd3, 2'd1, 2'd0};
        logic [1:0] exps [4] = '{2'b10, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            din_a = dins[i]; sel_a = sels[i]; mode_a = 1'b0; hold_a = 1'b0;
            sb_a.push_back('{data: exps[i], chan: sels[i], valid: 1'b1, wrap: 1'b0});
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL manual step%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("manual step%0d sel=%0d: data=%b chan=%0d valid=%b", i, sel_a, data_a, chan_a, valid_a);
        end
    endtask

    // Enters scan from chan 0; ends after 26 cycles with chan=2, dwell count=1.
    task automatic test_scan();
        din_a = 8'b11_10_01_00; mode_a = 1'b1; hold_a = 1'b0;
        for (int i = 0; i < 26; i++) begin
            sb_a.push_back('{data: 2'((i / 4) % 4), chan: 2'((i / 4) % 4), valid: 1'b1,
                             wrap: (i == 16)});
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL scan cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("scan cyc%0d: data=%b chan=%0d valid=%b wrap=%b", i, data_a, chan_a, valid_a, wrap_a);
        end
    endtask

    task automatic test_hold();
        din_a = 8'hFF; hold_a = 1'b1; mode_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb_a.push_back('{data: 2'b10, chan: 2'd2, valid: 1'b0, wrap: 1'b0});
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL hold cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("hold cyc%0d: data=%b chan=%0d valid=%b", i, data_a, chan_a, valid_a);
        end
        hold_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb_a.push_back('{data: 2'b11, chan: (i < 2) ? 2'd2 : 2'd3, valid: 1'b1, wrap: 1'b0});
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL resume cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("resume cyc%0d: data=%b chan=%0d valid=%b", i, data_a, chan_a, valid_a);
        end
    endtask

    // Scan back to manual, then hold with mode=1 (hold must win), then manual again.
    task automatic test_back_to_manual();
        logic       modes [3] = '{1'b0, 1'b1, 1'b0};
        logic       holds [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0] sels  [3] = '{2'd1, 2'd3, 2'd2};
        exp_t       exps  [3];
        exps[0] = '{data: 2'b01, chan: 2'd1, valid: 1'b1, wrap: 1'b0};
        exps[1] = '{data: 2'b01, chan: 2'd1, valid: 1'b0, wrap: 1'b0};
        exps[2] = '{data: 2'b10, chan: 2'd2, valid: 1'b1, wrap: 1'b0};
        din_a = 8'b11_10_01_00;
        for (int i = 0; i < 3; i++) begin
            mode_a = modes[i]; hold_a = holds[i]; sel_a = sels[i];
            sb_a.push_back(exps[i]);
            @(posedge clk); #1;
            e = sb_a.pop_front(); obs = {data_a, chan_a, valid_a, wrap_a};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL to_manual step%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("to_manual step%0d: data=%b chan=%0d valid=%b", i, data_a, chan_a, valid_a);
        end
    endtask

    task automatic test_out_of_range();
        din_b = 6'b10_01_11; mode_b = 1'b0; hold_b = 1'b0; sel_b = 2'd3;
        sb_b.push_back('{data: 2'b00, chan: 2'd3, valid: 1'b0, wrap: 1'b0});
        @(posedge clk); #1;
        e = sb_b.pop_front(); obs = {data_b, chan_b, valid_b, wrap_b};
        checks++;
        if (obs !== e) begin
            failures++;
            $display("FAIL oor_manual: got %b expected %b (data,chan,valid,wrap)", obs, e);
        end
        $display("oor manual sel=3: data=%b chan=%0d valid=%b", data_b, chan_b, valid_b);
        mode_b = 1'b1;
        for (int i = 0; i < 13; i++) begin
            sb_b.push_back('{data: tbl_b[(i / 4) % 3], chan: 2'((i / 4) % 3), valid: 1'b1,
                             wrap: (i == 12)});
            @(posedge clk); #1;
            e = sb_b.pop_front(); obs = {data_b, chan_b, valid_b, wrap_b};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL oor_scan cyc%0d: got %b expected %b (data,chan,valid,wrap)", i, obs, e);
            end
            $display("oor scan cyc%0d: data=%b chan=%0d wrap=%b", i, data_b, chan_b, wrap_b);
        end
        mode_b = 1'b0; sel_b = 2'd0;
    endtask

`ifdef CHAN_SCAN_PARITY_EN
    task automatic test_parity();
        logic [1:0] sels  [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd0};
        logic       holds [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        expp_t      exps  [5];
        exps[0] = '{data: 4'b1011, chan: 2'd0, valid: 1'b1, wrap: 1'b0, par: 1'b1};
        exps[1] = '{data: 4'b1001, chan: 2'd1, valid: 1'b1, wrap: 1'b0, par: 1'b0};
        exps[2] = '{data: 4'b0111, chan: 2'd2, valid: 1'b1, wrap: 1'b0, par: 1'b1};
        exps[3] = '{data: 4'b0111, chan: 2'd2, valid: 1'b0, wrap: 1'b0, par: 1'b1};
        exps[4] = '{data: 4'b1011, chan: 2'd0, valid: 1'b1, wrap: 1'b0, par: 1'b1};
        din_p = {4'h0, 4'b0111, 4'b1001, 4'b1011}; mode_p = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel_p = sels[i]; hold_p = holds[i];
            if (i == 3) din_p = 16'h0000;
            if (i == 4) din_p = {4'h0, 4'b0111, 4'b1001, 4'b1011};
            sb_p.push_back(exps[i]);
            @(posedge clk); #1;
            ep = sb_p.pop_front(); obsp = {data_p, chan_p, valid_p, wrap_p, par_p};
            checks++;
            if (obsp !== ep) begin
                failures++;
                $display("FAIL parity step%0d: got %b expected %b (data,chan,valid,wrap,par)", i, obsp, ep);
            end
            $display("parity step%0d: data=%b par=%b valid=%b", i, data_p, par_p, valid_p);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        din_a = '0; mode_a = 1'b0; hold_a = 1'b0; sel_a = '0;
        din_b = '0; mode_b = 1'b0; hold_b = 1'b0; sel_b = '0;
`ifdef CHAN_SCAN_PARITY_EN
        din_p = '0; mode_p = 1'b0; hold_p = 1'b0; sel_p = '0;
`endif
        test_reset();
        test_manual();
        test_scan();
        test_hold();
        test_back_to_manual();
        test_out_of_range();
`ifdef CHAN_SCAN_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
